// File: rtl/usb4_sb_crc_pkg.sv
// Shared constants and types for the sideband CRC-16 path.
// Used by both the transmit framer and the receive checker.
package usb4_sb_crc_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam int SYM_LEN = 10;
  localparam logic [3:0] CNT_LAST = 4'(SYM_LEN - 1);

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_DATA,
    TX_CRC_HI,
    TX_CRC_LO
  } tx_state_e;

endpackage

// File: rtl/crc16_lfsr_step.sv
// Single-bit CRC-16 LFSR update, MSB-first, x^16 implicit.
// Purely combinational; reused by tx framer and rx checker.
module crc16_lfsr_step #(
  parameter logic [15:0] POLY = 16'h8005
) (
  input  logic [15:0] crc_in,
  input  logic        bit_in,
  output logic [15:0] crc_out
);

  logic fb;

  // Feedback tap selects whether the polynomial is folded in.
  always_comb begin
    fb      = crc_in[15] ^ bit_in;
    crc_out = {crc_in[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  end

endmodule

// File: rtl/crc_16_trans_ser.sv
// Sideband serial tx framer: 10-bit symbols plus CRC-16 trailer.
// All outputs are registered decodes of the next state.
module crc_16_trans_ser
  import usb4_sb_crc_pkg::*;
#(
  parameter logic [15:0] CRC_POLY = CRC16_POLY,
  parameter logic [15:0] CRC_INIT = CRC16_INIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       tx_out,
  output logic       tx_en,
  output logic       done,
  output logic       underrun
);

  tx_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  byte_q, byte_d;
  logic        last_q, last_d;
  logic        tx_out_q, tx_out_d;
  logic        tx_en_q, tx_en_d;
  logic        s_ready_q, s_ready_d;
  logic        done_q, done_d;
  logic        underrun_q, underrun_d;

  logic [15:0] crc_step;
  logic        data_bit;
  logic        data_slot;
  logic        sym_end;
  logic        hs;

  assign data_bit  = byte_q[3'(cnt_q - 4'd1)];
  assign data_slot = (cnt_q >= 4'd1) && (cnt_q <= 4'd8);
  assign sym_end   = (cnt_q == CNT_LAST);
  assign hs        = s_valid && s_ready_q;

  crc16_lfsr_step #(
    .POLY(CRC_POLY)
  ) u_step (
    .crc_in (crc_q),
    .bit_in (data_bit),
    .crc_out(crc_step)
  );

  // Next state, counter, CRC and pulse generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    byte_d     = byte_q;
    last_d     = last_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        crc_d = CRC_INIT;
        cnt_d = 4'd0;
        if (hs) begin
          byte_d  = s_data;
          last_d  = s_last;
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (data_slot) crc_d = crc_step;
        if (sym_end) begin
          cnt_d = 4'd0;
          if (hs) begin
            byte_d = s_data;
            last_d = s_last;
          end else begin
            state_d    = TX_CRC_HI;
            underrun_d = !last_q;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      TX_CRC_HI, TX_CRC_LO: begin
        if (data_slot) crc_d = {crc_q[14:0], 1'b0};
        if (sym_end) begin
          cnt_d = 4'd0;
          if (state_q == TX_CRC_HI) begin
            state_d = TX_CRC_LO;
          end else begin
            state_d = TX_IDLE;
            done_d  = 1'b1;
            crc_d   = CRC_INIT;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Output decode from the upcoming state so outputs are flops.
  always_comb begin
    tx_en_d   = (state_d != TX_IDLE);
    s_ready_d = (state_d == TX_IDLE)
             || ((state_d == TX_DATA)
              && (cnt_d == CNT_LAST)
              && !last_d);
    if (state_d == TX_IDLE)
      tx_out_d = STOP_BIT;
    else if (cnt_d == 4'd0)
      tx_out_d = START_BIT;
    else if (cnt_d == CNT_LAST)
      tx_out_d = STOP_BIT;
    else if (state_d == TX_DATA)
      tx_out_d = byte_d[3'(cnt_d - 4'd1)];
    else
      tx_out_d = crc_d[15];
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= TX_IDLE;
      cnt_q      <= 4'd0;
      crc_q      <= CRC_INIT;
      byte_q     <= 8'h00;
      last_q     <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_en_q    <= 1'b0;
      s_ready_q  <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      crc_q      <= crc_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      tx_out_q   <= tx_out_d;
      tx_en_q    <= tx_en_d;
      s_ready_q  <= s_ready_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign tx_out   = tx_out_q;
  assign tx_en    = tx_en_q;
  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: doc/crc_16_trans_ser.md
# crc_16_trans_ser

Transmit-side framer and CRC-16 generator for the sideband serial path. It accepts packet bytes over a valid/ready handshake and serialises each one as a 10-bit symbol: start bit 0, eight data bits LSB-first, stop bit 1. It computes CRC-16 (poly 0x8005, init 0xFFFF) over the transmitted data bits and appends the CRC as two further symbols. Its `tx_out`/`tx_en` pair drives the downstream CRC-16 receive checker directly; `tx_en` frames the packet.

## Interface
- `CRC_POLY`, default 16'h8005: generator polynomial, x^16 term implicit.
- `CRC_INIT`, default 16'hFFFF: CRC register value at packet start.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `s_data`, in, 8: packet byte.
- `s_valid`, in, 1: `s_data`/`s_last` valid.
- `s_last`, in, 1: current byte is the final data byte of the packet.
- `s_ready`, out, 1: byte accepted on a rising edge where `s_valid && s_ready`.
- `tx_out`, out, 1: serial line, registered.
- `tx_en`, out, 1: high for every bit of the packet's symbols, low between packets.
- `done`, out, 1: one-cycle pulse on the first cycle after the last CRC stop bit.
- `underrun`, out, 1: one-cycle pulse when a mid-packet byte is not available.

## Operation
- States: IDLE, DATA, CRC_HI, CRC_LO. Bit counter `cnt` runs 0..9 and wraps to 0 on each symbol boundary.
- Reset values: state=IDLE, cnt=0, crc=CRC_INIT, `tx_out`=1, `tx_en`=0, `s_ready`=0, `done`=0, `underrun`=0.
- IDLE:
  - `s_ready`=1, `tx_out`=1, `tx_en`=0, crc held at CRC_INIT.
  - Handshake: latch byte and `s_last`, go to DATA with cnt=0.
- DATA symbol bit mapping:
  - cnt=0: `tx_out`=0 (start bit).
  - cnt=1..8: `tx_out`=byte[cnt-1].
  - cnt=9: `tx_out`=1 (stop bit).
- CRC update, applied on data bits only (cnt 1..8):
  - fb = crc[15] ^ bit.
  - crc <= {crc[14:0],1'b0} ^ (fb ? CRC_POLY : 0).
- DATA, cnt=9:
  - If the latched last flag is clear, `s_ready`=1 for that single cycle.
  - Handshake: latch the next byte and continue in DATA (back-to-back, no gap).
  - No `s_valid`: pulse `underrun` and treat the packet as ended (go to CRC_HI).
  - Latched last flag set: go to CRC_HI.
- CRC_HI / CRC_LO:
  - Same start/stop framing.
  - Data slots emit crc[15], then shift crc left by one with zero fill. No further CRC update.
  - CRC_HI carries the final CRC[15:8] MSB-first; CRC_LO carries CRC[7:0] MSB-first.
  - A receiver running the same LFSR over data and CRC bits ends with residue 0x0000.
- After CRC_LO cnt=9: return to IDLE, `tx_en`=0, pulse `done`, reload crc=CRC_INIT.
- `s_ready` is 0 in every state and cycle not listed above.
- Reset mid-packet: immediate return to reset values. No CRC symbols are sent and no `done` pulse is generated.

## Timing
- Byte accepted in IDLE at edge N: `tx_en`=1 and the start bit appear on `tx_out` from cycle N+1.
- A packet of n data bytes keeps `tx_en` high for exactly 10·(n+2) consecutive cycles.
- `tx_en` is low for at least 1 cycle between packets, because IDLE lasts at least one cycle. A new packet's byte can be accepted in the cycle `done` is high.
- All outputs are registered. `s_ready` is a registered decode of state/cnt and never depends combinationally on `s_valid`.
- Simultaneous `s_last` and underrun cannot occur: an underrun only exists when no byte is presented.

## Structure
- Shared package `usb4_sb_crc_pkg` holds:
  - CRC16_POLY and CRC16_INIT constants.
  - SYM_LEN=10 and the START/STOP bit values.
  - The tx state enum.
- The package is shared with the receive checker.
- Sub-module `crc16_lfsr_step`: combinational single-bit update (crc_in, bit_in → crc_out), parameterised by POLY. The tx side and the rx model both reuse it.

## Test plan
- Reset, then idle: `tx_out`=1, `tx_en`=0, `s_ready`=1, no pulses for 50 cycles.
- Single byte 0x00 with `s_last`=1:
  - 30 `tx_en` cycles.
  - Line: 0 00000000 1 | 0 11111101 1 | 0 00000010 1 (CRC=0xFD02).
  - `done` on cycle 31.
- Back-to-back 0x00 followed by 0xA5 (LSB-first 10100101), with `s_valid` held:
  - 40 contiguous `tx_en` cycles and no idle gap.
  - Bench LFSR model matches the CRC symbols, and the residue over all 32 bits is 0x0000.
- Underrun: first byte 0x00 with `s_last`=0 and `s_valid` dropped:
  - `underrun` pulses at cnt=9.
  - CRC 0xFD02 follows immediately.
  - `done` pulses.
- Reset asserted at cnt=5 of the second data symbol: `tx_out`=1 and `tx_en`=0 asynchronously. The next packet starts with crc=0xFFFF.
- Random packets of 1–16 bytes fed into the receive checker: checker reports no error. A single flipped `tx_out` bit makes the checker report an error.
